// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential array multiplier.
// FSM state encodings and a constant clog2 for counter sizing.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/add_row.sv
// One shift-add row: WIDTH-bit ripple adder of full-adder cells.
// The carry-out is kept so the accumulate step never loses a bit.
module add_row #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/seq_array_multiplier.sv
// Sequential WIDTH x WIDTH shift-add multiplier, one row per clock.
// Signed mode multiplies magnitudes and negates the result at the end.
module seq_array_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE_W = 1;
  localparam logic [2*WIDTH-1:0] ONE_P = 1;

  state_e state_q, state_d;
  logic neg_q, neg_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic mode;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] addend, sum;
  logic carry;
  logic [2*WIDTH-1:0] acc_nx;

  // -2^(W-1) negates to itself, which reads correctly as unsigned
  assign mode  = signed_mode & SIGNED_EN;
  assign mag_a = (mode && a[WIDTH-1]) ? (~a + ONE_W) : a;
  assign mag_b = (mode && b[WIDTH-1]) ? (~b + ONE_W) : b;

  assign addend = mplier_q[0] ? mcand_q : '0;

  add_row #(
    .WIDTH(WIDTH)
  ) u_row (
    .a    (acc_q[2*WIDTH-1:WIDTH]),
    .b    (addend),
    .sum  (sum),
    .cout (carry)
  );

  assign acc_nx = {carry, sum, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    neg_d     = neg_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mcand_d  = mag_a;
          mplier_d = mag_b;
          neg_d    = mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d    = acc_nx;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d   = ST_DONE;
          product_d = neg_q ? (~acc_nx + ONE_P) : acc_nx;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      neg_q     <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      neg_q     <= neg_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed plus random bench for seq_array_multiplier (WIDTH=4).
// Two instances: signed mode enabled and signed mode disabled.
module tb_seq_array_multiplier;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic [W-1:0] a, b;
  logic signed_mode;
  logic out_ready;

  logic in_ready, out_valid, busy;
  logic [2*W-1:0] product;
  logic ns_in_ready, ns_out_valid, ns_busy;
  logic [2*W-1:0] ns_product;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_array_multiplier #(
    .WIDTH(W),
    .SIGNED_EN(1'b1)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy)
  );

  seq_array_multiplier #(
    .WIDTH(W),
    .SIGNED_EN(1'b0)
  ) u_ns (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (ns_in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (ns_out_valid),
    .out_ready   (out_ready),
    .product     (ns_product),
    .busy        (ns_busy)
  );

  function automatic logic [2*W-1:0] ref_mul(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input bit sm
  );
    int xi, yi;
    if (sm) begin
      xi = $signed(x);
      yi = $signed(y);
    end else begin
      xi = int'(x);
      yi = int'(y);
    end
    return (2*W)'(xi * yi);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered #1 after a rising edge with both DUTs idle.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit sm, input string tag, input bit retire);
    int n;
    a = x;
    b = y;
    signed_mode = sm;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    signed_mode = 1'($urandom);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    n = 1;
    while (!out_valid && n < W + 6) begin
      tick();
      if (!out_valid) n++;
    end
    if (!out_valid) n = 0;
    chk({tag, " latency"}, 32'(n), 32'(W));
    chk({tag, " product"}, 32'(product), 32'(ref_mul(x, y, sm)));
    chk({tag, " ns product"}, 32'(ns_product), 32'(ref_mul(x, y, 1'b0)));
    if (retire) begin
      out_ready = 1'b1;
      tick();
      chk({tag, " retire valid"}, 32'(out_valid), 32'd0);
      chk({tag, " retire ready"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [2*W-1:0] held;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    signed_mode = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst product", 32'(product), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    do_op(4'hF, 4'hF, 1'b0, "ufull", 1'b0);
    chk("ufull const", 32'(product), 32'h00E1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    do_op(4'h8, 4'h8, 1'b1, "smin", 1'b1);
    out_ready = 1'b0;
    do_op(4'hD, 4'h5, 1'b1, "sneg", 1'b1);
    out_ready = 1'b0;
    do_op(4'h0, 4'hB, 1'b1, "zero", 1'b1);
    out_ready = 1'b0;
    do_op(4'hF, 4'h1, 1'b1, "gate", 1'b1);
    out_ready = 1'b0;

    // Backpressure with a competing request held high
    do_op(4'hA, 4'h3, 1'b0, "bp", 1'b0);
    held = product;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      tick();
      chk("bp stable", 32'(product), 32'(held));
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp idle", 32'(in_ready), 32'd1);
    chk("bp no valid", 32'(out_valid), 32'd0);
    chk("bp keep", 32'(product), 32'(held));

    // Back-to-back with out_ready tied high
    out_ready = 1'b1;
    do_op(4'd7, 4'd9, 1'b0, "b2b0", 1'b1);
    do_op(4'd12, 4'd3, 1'b0, "b2b1", 1'b1);
    do_op(4'd1, 4'd1, 1'b0, "b2b2", 1'b1);
    out_ready = 1'b0;

    // Asynchronous reset two edges into RUN
    a = 4'd9;
    b = 4'd7;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst in_ready", 32'(in_ready), 32'd1);
    chk("mrst out_valid", 32'(out_valid), 32'd0);
    chk("mrst busy", 32'(busy), 32'd0);
    chk("mrst product", 32'(product), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst stale", 32'(out_valid), 32'd0);
    end
    do_op(4'd6, 4'd6, 1'b0, "post", 1'b1);
    out_ready = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), "rnd", 1'b1);
      out_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
